pwm_deadtime: RTL and testbench

- Complementary-output dead-time inserter, directly downstream of the PWM modulator.
- Consumes the modulator's single-ended `pwm_out` and drives high-side and low-side gate signals. The two are never high together, and every changeover has a programmable break-before-make gap.
- Runs on the system clock; `pwm_in` may come from a divided-clock domain, so it is synchronised internally.

---
 rtl/pwm_deadtime.sv | 155 +++++++++++++++
 tb/tb_pwm_deadtime.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Complementary high/low gate driver with a programmable break-before-make dead time.
// Define PWM_DEADTIME_FAULT_EN to add a latched, synchronised fault input.
module pwm_deadtime #(
   parameter int unsigned         DT_WIDTH   = 8,
   parameter logic [DT_WIDTH-1:0] DEFAULT_DT = DT_WIDTH'(4)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                en,
   input  logic                wr_dead_time,
   input  logic [DT_WIDTH-1:0] dead_time,
   input  logic                pwm_in,
`ifdef PWM_DEADTIME_FAULT_EN
   input  logic                fault,
`endif
   output logic                out_hi,
   output logic                out_lo,
   output logic                dt_active,
   output logic                short_pulse
);

   typedef enum logic [2:0] {
      StOff,
      StDtToLo,
      StLoOn,
      StDtToHi,
      StHiOn
`ifdef PWM_DEADTIME_FAULT_EN
      , StFault
`endif
   } state_e;

   state_e              state_q, state_d;
   logic [DT_WIDTH-1:0] cnt_q, cnt_d;
   logic [DT_WIDTH-1:0] dt_q;
   logic                pwm_r1, pwm_s;
   logic                wr_r1, wr_r2;
   logic                wr_pulse;
   logic                sp_set;
`ifdef PWM_DEADTIME_FAULT_EN
   logic                fault_r1, fault_s;
`endif

   assign wr_pulse = wr_r1 & ~wr_r2;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_r1   <= 1'b0;
         pwm_s    <= 1'b0;
         wr_r1    <= 1'b0;
         wr_r2    <= 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
         fault_r1 <= 1'b0;
         fault_s  <= 1'b0;
`endif
      end else begin
         pwm_r1   <= pwm_in;
         pwm_s    <= pwm_r1;
         wr_r1    <= wr_dead_time;
         wr_r2    <= wr_r1;
`ifdef PWM_DEADTIME_FAULT_EN
         fault_r1 <= fault;
         fault_s  <= fault_r1;
`endif
      end
   end

   // A write and a short-pulse detection on the same edge: the write's clear wins.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StOff;
         cnt_q       <= '0;
         dt_q        <= DEFAULT_DT;
         short_pulse <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (wr_pulse) begin
            dt_q        <= dead_time;
            short_pulse <= 1'b0;
         end else if (sp_set) begin
            short_pulse <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sp_set  = 1'b0;
`ifdef PWM_DEADTIME_FAULT_EN
      if (fault_s) begin
         state_d = StFault;
         cnt_d   = '0;
      end else if (state_q == StFault) begin
         cnt_d = '0;
         if (!en) state_d = StOff;
      end else
`endif
      if (!en) begin
         state_d = StOff;
         cnt_d   = '0;
      end else begin
         case (state_q)
            StOff: begin
               state_d = StDtToLo;
               cnt_d   = dt_q;
            end
            StLoOn: begin
               if (pwm_s) begin
                  state_d = StDtToHi;
                  cnt_d   = dt_q;
               end
            end
            StDtToHi: begin
               if (!pwm_s) begin
                  state_d = StLoOn;
                  sp_set  = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d = StHiOn;
               end else begin
                  cnt_d = cnt_q - DT_WIDTH'(1);
               end
            end
            StHiOn: begin
               if (!pwm_s) begin
                  state_d = StDtToLo;
                  cnt_d   = dt_q;
               end
            end
            StDtToLo: begin
               if (pwm_s) begin
                  state_d = StDtToHi;
                  cnt_d   = dt_q;
                  sp_set  = 1'b1;
               end else if (cnt_q == '0) begin
                  state_d = StLoOn;
               end else begin
                  cnt_d = cnt_q - DT_WIDTH'(1);
               end
            end
            default: begin
               state_d = StOff;
               cnt_d   = '0;
            end
         endcase
      end
   end

   // Outputs decode the state register only, so the two drives can never overlap.
   assign out_hi    = (state_q == StHiOn);
   assign out_lo    = (state_q == StLoOn);
   assign dt_active = (state_q == StDtToHi) || (state_q == StDtToLo);

endmodule

// File: tb/tb_pwm_deadtime.sv
// Self-checking bench for pwm_deadtime: vector table, directed corner sequences and a
// random run-length model of the dead-time rules.
module tb_pwm_deadtime;
   localparam int DTW = 8;

   logic           clk = 1'b0;
   logic           rst, en, wr_dead_time, pwm_in;
   logic [DTW-1:0] dead_time;
   logic           out_hi, out_lo, dt_active, short_pulse;
`ifdef PWM_DEADTIME_FAULT_EN
   logic           fault;
`endif
   int total = 0;
   int bad   = 0;
   logic hist[$];

   always #5 clk = ~clk;

   pwm_deadtime #(.DT_WIDTH(DTW), .DEFAULT_DT(8'd4)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .wr_dead_time (wr_dead_time),
      .dead_time    (dead_time),
      .pwm_in       (pwm_in),
`ifdef PWM_DEADTIME_FAULT_EN
      .fault        (fault),
`endif
      .out_hi       (out_hi),
      .out_lo       (out_lo),
      .dt_active    (dt_active),
      .short_pulse  (short_pulse)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) if (!rst) check("no_overlap", {31'd0, out_hi & out_lo}, 0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_dt(input int v);
      dead_time    = DTW'(v);
      wr_dead_time = 1'b1;
      repeat (3) tick();
      wr_dead_time = 1'b0;
      repeat (3) tick();
   endtask

   task automatic wait_lo(input string name);
      int i = 0;
      while (!out_lo && i < 600) begin
         tick();
         i++;
      end
      check(name, out_lo, 1);
   endtask

   // Waits for a dead-time interval to start, then returns its length in cycles.
   task automatic measure_gap(output int n);
      int i = 0;
      n = 0;
      while (!dt_active && i < 400) begin
         tick();
         i++;
      end
      while (dt_active && n < 600) begin
         n++;
         tick();
      end
   endtask

   task automatic step(input logic v);
      pwm_in = v;
      hist.push_back(v);
      tick();
   endtask

   typedef struct {
      int dt;
      int width;
      int hi;
      int gap;
      int sp;
      int rise;
   } vec_t;

   vec_t tbl[9];

   initial begin
      int n, hi_n, gap_n, rise, c;
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n, hi_n, gap_n, rise, c, d, len, i;
      logic sticky, lvl, all_hi, all_lo;

      // {dead_time, pulse width, out_hi cycles, both-low cycles, short flag, rise offset}
      tbl[0] = '{3, 10, 6, 8, 0, 6};
      tbl[1] = '{3, 32, 28, 8, 0, 6};
      tbl[2] = '{3, 5, 1, 8, 0, 6};
      tbl[3] = '{3, 4, 0, 4, 1, -1};
      tbl[4] = '{0, 2, 1, 2, 0, 3};
      tbl[5] = '{0, 1, 0, 1, 1, -1};
      tbl[6] = '{10, 3, 0, 3, 1, -1};
      tbl[7] = '{10, 12, 1, 22, 0, 13};
      tbl[8] = '{255, 258, 2, 512, 0, 258};

      rst = 1'b1; en = 1'b0; wr_dead_time = 1'b0; pwm_in = 1'b0; dead_time = '0;
`ifdef PWM_DEADTIME_FAULT_EN
      fault = 1'b0;
`endif
      repeat (2) tick();
      check("rst_hi", out_hi, 0);
      check("rst_lo", out_lo, 0);
      check("rst_dt", dt_active, 0);
      check("rst_sp", short_pulse, 0);
      rst = 1'b0;
      repeat (3) tick();
      check("off_hi", out_hi, 0);
      check("off_lo", out_lo, 0);
      check("off_dt", dt_active, 0);
      en = 1'b1;
      measure_gap(n);
      check("startup_gap", n, 5);
      check("startup_lo", out_lo, 1);

      foreach (tbl[k]) begin
         write_dt(tbl[k].dt);
         wait_lo("tbl_settle");
         check("tbl_sp_clear", short_pulse, 0);
         hi_n = 0; gap_n = 0; rise = -1; c = 0;
         pwm_in = 1'b1;
         repeat (tbl[k].width) begin
            tick();
            if (out_hi) begin
               hi_n++;
               if (rise < 0) rise = c;
            end
            if (!out_hi && !out_lo) gap_n++;
            c++;
         end
         pwm_in = 1'b0;
         repeat (2 * tbl[k].dt + 12) begin
            tick();
            if (out_hi) begin
               hi_n++;
               if (rise < 0) rise = c;
            end
            if (!out_hi && !out_lo) gap_n++;
            c++;
         end
         check("tbl_hi_cycles", hi_n, tbl[k].hi);
         check("tbl_gap_cycles", gap_n, tbl[k].gap);
         check("tbl_rise", rise, tbl[k].rise);
         check("tbl_short", short_pulse, tbl[k].sp);
         check("tbl_end_lo", out_lo, 1);
      end

      // Write lands during a running interval; only the following load sees it.
      write_dt(2);
      wait_lo("mid_settle");
      pwm_in = 1'b1;
      i = 0;
      while (!dt_active && i < 20) begin
         tick();
         i++;
      end
      dead_time = 8'd20;
      wr_dead_time = 1'b1;
      n = 0;
      while (dt_active && n < 50) begin
         n++;
         if (n == 2) wr_dead_time = 1'b0;
         tick();
      end
      wr_dead_time = 1'b0;
      check("mid_write_gap", n, 3);
      check("mid_write_hi", out_hi, 1);
      repeat (5) tick();
      pwm_in = 1'b0;
      measure_gap(n);
      check("next_gap", n, 21);
      check("next_gap_lo", out_lo, 1);

      pwm_in = 1'b1;
      i = 0;
      while (!out_hi && i < 60) begin
         tick();
         i++;
      end
      check("reach_hi", out_hi, 1);
      en = 1'b0;
      tick();
      check("en_drop_hi", out_hi, 0);
      check("en_drop_lo", out_lo, 0);
      check("en_drop_dt", dt_active, 0);

      pwm_in = 1'b0;
      en = 1'b1;
      repeat (2) tick();
      check("pre_rst_dt", dt_active, 1);
      rst = 1'b1;
      #1;
      check("async_rst_hi", out_hi, 0);
      check("async_rst_lo", out_lo, 0);
      check("async_rst_dt", dt_active, 0);
      tick();
      rst = 1'b0;
      measure_gap(n);
      check("rst_default_gap", n, 5);

      // Random pulse trains: out_hi must equal "last D+2 samples high", low side symmetric.
      for (int seg = 0; seg < 6; seg++) begin
         d = $urandom_range(0, 6);
         write_dt(d);
         wait_lo("rnd_settle");
         hist.delete();
         sticky = 1'b0;
         lvl = 1'b1;
         for (int r = 0; r < 13; r++) begin
            len = (r == 12) ? d + 12 : $urandom_range(1, d + 4);
            if (r < 11 && len < d + 2) sticky = 1'b1;
            repeat (len) begin
               step(r == 12 ? 1'b0 : lvl);
               n = hist.size() - 1;
               if (n >= d + 3) begin
                  all_hi = 1'b1;
                  all_lo = 1'b1;
                  for (int j = 0; j <= d + 1; j++) begin
                     all_hi &= hist[n - 2 - j];
                     all_lo &= ~hist[n - 2 - j];
                  end
                  check("rnd_hi", out_hi, all_hi);
                  if (all_lo) check("rnd_lo_on", out_lo, 1);
                  if (hist[n - 2]) check("rnd_lo_off", out_lo, 0);
                  check("rnd_dt", dt_active, !(out_hi || out_lo));
               end
            end
            lvl = ~lvl;
         end
         check("rnd_short", short_pulse, sticky);
      end

`ifdef PWM_DEADTIME_FAULT_EN
      write_dt(4);
      wait_lo("flt_settle");
      pwm_in = 1'b1;
      i = 0;
      while (!out_hi && i < 30) begin
         tick();
         i++;
      end
      check("flt_pre_hi", out_hi, 1);
      fault = 1'b1;
      tick();
      fault = 1'b0;
      repeat (2) tick();
      check("flt_hi", out_hi, 0);
      check("flt_lo", out_lo, 0);
      check("flt_dt", dt_active, 0);
      repeat (10) tick();
      check("flt_hold_hi", out_hi, 0);
      check("flt_hold_lo", out_lo, 0);
      check("flt_hold_dt", dt_active, 0);
      en = 1'b0;
      repeat (2) tick();
      en = 1'b1;
      measure_gap(n);
      check("flt_restart_gap", n, 5);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
